pipeline_stall_controller: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline's stall and flush controls.
- Merges three inputs into one consistent set of register-write, bubble and flush enables for PC, IF/ID and the later pipeline registers:
  - the combinational load-use hazard flag from hazard detection;
  - the ID-stage branch/jump redirect;
  - the MEM-stage data-memory busy flag.
- Adds a start gate, a one-cycle mask on the hazard flag after a bubble, a memory-wait timeout, and performance counters.

---
 rtl/pipeline_stall_controller.sv | 110 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: merges load-use, redirect and
// data-memory busy into PC/IF-ID/pipeline enables, with start gate, timeout and counters.
module pipeline_stall_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             redirect_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             ctrl_zero_o,
  output logic             pipe_freeze_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StLuBubble = 2'd2,
    StMemWait  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use_eff;

  // The bubble cycle re-presents the same ID instruction, so its hazard flag is stale.
  assign load_use_eff = load_use_i && (state_q != StLuBubble);

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    ctrl_zero_o   = 1'b0;
    pipe_freeze_o = 1'b0;
    state_d       = StRun;
    if (state_q == StIdle) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      ctrl_zero_o   = 1'b1;
      pipe_freeze_o = 1'b1;
      state_d       = start_i ? StRun : StIdle;
    end else if (dmem_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_freeze_o = 1'b1;
      state_d       = StMemWait;
    end else if (load_use_eff) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      ctrl_zero_o   = 1'b1;
      state_d       = StLuBubble;
    end else if (redirect_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (state_q != StIdle && dmem_stall_i) begin
      wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (wait_cnt_d == WaitMax);

    stall_cnt_d = stall_cnt_q;
    if (state_q != StIdle && !pc_write_o) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (if_id_flush_o) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (default and CNT_W=2/MEM_TIMEOUT=4)
// share stimulus and are checked against directed expectations and a behavioural model.
module tb_pipeline_stall_controller;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1, start_i = 1'b0, load_use_i = 1'b0, redirect_i = 1'b0;
  logic dmem_stall_i = 1'b0;

  logic        pc_w, ifid_w, flush, czero, freeze, tmo;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state;
  logic        pc_w2, ifid_w2, flush2, czero2, freeze2, tmo2;
  logic [1:0]  stall_cnt2, flush_cnt2;
  logic [1:0]  state2;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  pipeline_stall_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_use_i(load_use_i),
    .redirect_i(redirect_i), .dmem_stall_i(dmem_stall_i), .pc_write_o(pc_w),
    .if_id_write_o(ifid_w), .if_id_flush_o(flush), .ctrl_zero_o(czero),
    .pipe_freeze_o(freeze), .mem_timeout_o(tmo), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt), .state_o(state)
  );

  pipeline_stall_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_use_i(load_use_i),
    .redirect_i(redirect_i), .dmem_stall_i(dmem_stall_i), .pc_write_o(pc_w2),
    .if_id_write_o(ifid_w2), .if_id_flush_o(flush2), .ctrl_zero_o(czero2),
    .pipe_freeze_o(freeze2), .mem_timeout_o(tmo2), .stall_cnt_o(stall_cnt2),
    .flush_cnt_o(flush_cnt2), .state_o(state2)
  );

  // Reference model: tracks "started", "bubble just issued", "waiting on memory".
  logic        m_run = 1'b0, m_bub = 1'b0, m_wait = 1'b0, m_to = 1'b0, m_to2 = 1'b0;
  int          m_wcnt = 0;
  logic [31:0] m_stall = '0, m_flush = '0;
  logic        e_pc, e_ifid, e_fl, e_cz, e_fr;
  logic [1:0]  e_state;

  always_comb begin
    e_state = !m_run ? 2'd0 : m_bub ? 2'd2 : m_wait ? 2'd3 : 2'd1;
    {e_pc, e_ifid, e_fl, e_cz, e_fr} = 5'b11000;
    if (!m_run)                        {e_pc, e_ifid, e_fl, e_cz, e_fr} = 5'b00011;
    else if (dmem_stall_i)             {e_pc, e_ifid, e_fl, e_cz, e_fr} = 5'b00001;
    else if (load_use_i && !m_bub)     {e_pc, e_ifid, e_fl, e_cz, e_fr} = 5'b00010;
    else if (redirect_i)               {e_pc, e_ifid, e_fl, e_cz, e_fr} = 5'b11100;
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_run <= 1'b0; m_bub <= 1'b0; m_wait <= 1'b0; m_to <= 1'b0; m_to2 <= 1'b0;
      m_wcnt <= 0; m_stall <= '0; m_flush <= '0;
    end else if (!m_run) begin
      m_run <= start_i;
      m_wcnt <= 0;
    end else begin
      if (!e_pc) m_stall <= m_stall + 1;
      if (e_fl)  m_flush <= m_flush + 1;
      m_wait <= dmem_stall_i;
      m_bub  <= !dmem_stall_i && load_use_i && !m_bub;
      if (dmem_stall_i) begin
        m_wcnt <= m_wcnt + 1;
        if (m_wcnt + 1 >= 64) m_to <= 1'b1;
        if (m_wcnt + 1 >= 4)  m_to2 <= 1'b1;
      end else begin
        m_wcnt <= 0;
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic lu, input logic rd,
                       input logic dm);
    @(negedge clk_i);
    rst_i = r; start_i = s; load_use_i = lu; redirect_i = rd; dmem_stall_i = dm;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({pc_w, ifid_w, flush, czero, freeze} !== 5'b00011) begin
      errors++; $display("FAIL reset_outs got=%b exp=00011", {pc_w, ifid_w, flush, czero, freeze});
    end
    checks++; if ({stall_cnt, flush_cnt, tmo} !== 33'd0) begin
      errors++; $display("FAIL reset_cnts got=%0d/%0d/%b exp=0/0/0", stall_cnt, flush_cnt, tmo);
    end
  endtask

  task automatic test_start_gate();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++; if ({state, pc_w, czero} !== 4'b0001) begin
        errors++; $display("FAIL gate_idle[%0d] got=%b exp=0001", i, {state, pc_w, czero});
      end
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++; if ({state, pc_w} !== 3'b011) begin
      errors++; $display("FAIL gate_run got=%b exp=011", {state, pc_w});
    end
    checks++; if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL gate_stall_cnt got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    drive(0, 0, 1, 1, 0);
    checks++; if ({pc_w, czero, flush} !== 3'b010) begin
      errors++; $display("FAIL lu_c1 got=%b exp=010", {pc_w, czero, flush});
    end
    drive(0, 0, 1, 1, 0);
    checks++; if ({state, pc_w, flush} !== 4'b1011) begin
      errors++; $display("FAIL lu_c2 got=%b exp=1011", {state, pc_w, flush});
    end
    drive(0, 0, 0, 0, 0);
    checks++; if ({state, stall_cnt, flush_cnt} !== {2'd1, 16'd1, 16'd1}) begin
      errors++; $display("FAIL lu_cnts got=%0d/%0d/%0d exp=1/1/1", state, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_mem_stall();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1, 0, 1);
      checks++; if ({freeze, pc_w} !== 2'b10) begin
        errors++; $display("FAIL ms_freeze[%0d] got=%b exp=10", k, {freeze, pc_w});
      end
      if (k > 1) begin
        checks++; if (state !== 2'd3) begin
          errors++; $display("FAIL ms_state[%0d] got=%0d exp=3", k, state);
        end
      end
    end
    drive(0, 0, 1, 0, 0);
    checks++; if ({state, czero, pc_w, freeze} !== 5'b11100) begin
      errors++; $display("FAIL ms_release got=%b exp=11100", {state, czero, pc_w, freeze});
    end
    checks++; if (stall_cnt !== 16'd6) begin
      errors++; $display("FAIL ms_stall_cnt got=%0d exp=6", stall_cnt);
    end
    checks++; if ({tmo, tmo2} !== 2'b01) begin
      errors++; $display("FAIL ms_timeouts got=%b exp=01", {tmo, tmo2});
    end
    drive(0, 0, 0, 0, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL ms_bubble got=%0d exp=2", state); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 1, 0, 0, 1);
      checks++; if (tmo2 !== (k >= 5)) begin
        errors++; $display("FAIL to_rise[%0d] got=%b exp=%b", k, tmo2, k >= 5);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0);
      checks++; if ({tmo, tmo2} !== 2'b01) begin
        errors++; $display("FAIL to_sticky[%0d] got=%b exp=01", k, {tmo, tmo2});
      end
    end
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++; if (tmo2 !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", tmo2); end
  endtask

  task automatic test_reset_mid_stall();
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL rms_wait got=%0d exp=3", state); end
    drive(1, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1);
    checks++; if ({state, stall_cnt, flush_cnt, tmo, state2, stall_cnt2, tmo2} !== '0) begin
      errors++; $display("FAIL rms_clear got=%0d/%0d/%0d/%b/%0d/%0d/%b exp=all0", state, stall_cnt,
                         flush_cnt, tmo, state2, stall_cnt2, tmo2);
    end
  endtask

  task automatic test_counter_wrap();
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    checks++; if ({flush_cnt2, flush_cnt} !== {2'd1, 16'd5}) begin
      errors++; $display("FAIL wrap got=%0d/%0d exp=1/5", flush_cnt2, flush_cnt);
    end
  endtask

  task automatic test_random();
    int burst = 0;
    logic dm;
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      dm = 1'b0;
      if (burst > 0) begin
        dm = 1'b1; burst--;
      end else if ($urandom_range(0, 11) == 0) begin
        burst = $urandom_range(1, 7);
      end
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), dm);
      checks++; if ({state, state2} !== {e_state, e_state}) begin
        errors++; $display("FAIL rnd_state[%0d] got=%0d/%0d exp=%0d", c, state, state2, e_state);
      end
      checks++;
      if ({pc_w, ifid_w, flush, czero, freeze} !== {e_pc, e_ifid, e_fl, e_cz, e_fr} ||
          {pc_w2, ifid_w2, flush2, czero2, freeze2} !== {e_pc, e_ifid, e_fl, e_cz, e_fr}) begin
        errors++; $display("FAIL rnd_outs[%0d] got=%b/%b exp=%b", c,
                           {pc_w, ifid_w, flush, czero, freeze},
                           {pc_w2, ifid_w2, flush2, czero2, freeze2},
                           {e_pc, e_ifid, e_fl, e_cz, e_fr});
      end
      checks++;
      if (stall_cnt !== m_stall[15:0] || flush_cnt !== m_flush[15:0] ||
          stall_cnt2 !== m_stall[1:0] || flush_cnt2 !== m_flush[1:0]) begin
        errors++; $display("FAIL rnd_cnts[%0d] got=%0d/%0d/%0d/%0d exp=%0d/%0d", c, stall_cnt,
                           flush_cnt, stall_cnt2, flush_cnt2, m_stall, m_flush);
      end
      checks++; if ({tmo, tmo2} !== {m_to, m_to2}) begin
        errors++; $display("FAIL rnd_tmo[%0d] got=%b exp=%b", c, {tmo, tmo2}, {m_to, m_to2});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_gate();
    test_load_use();
    test_mem_stall();
    test_timeout();
    test_reset_mid_stall();
    test_counter_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
